// File: rtl/ovc_sched.sv
// Output-port scheduler: round-robin VC allocation on head flits, credit-gated
// round-robin switch allocation, and per-VC downstream credit tracking.
module ovc_sched #(
  parameter int NR   = 8,
  parameter int VCN  = 2,
  parameter int FCPD = 1,
  parameter int CW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR-1:0]     vreq,
  output logic [NR-1:0]     vgnt,
  output logic [VCN-1:0]    vgnt_vc,
  input  logic [NR-1:0]     freq,
  input  logic [NR-1:0]     ftail,
  output logic [NR-1:0]     fgnt,
  output logic [VCN-1:0]    fvc,
  output logic              fvld,
  input  logic [VCN-1:0]    credit,
  output logic [VCN-1:0]    vc_busy,
  output logic [VCN*CW-1:0] cr_cnt,
  output logic              cr_err
);

  localparam int IW = (NR > 1) ? $clog2(NR) : 1;
  localparam int VW = (VCN > 1) ? $clog2(VCN) : 1;

  logic [VCN-1:0] owned;
  logic [IW-1:0]  owner [VCN];
  logic [CW-1:0]  cr    [VCN];
  logic [IW-1:0]  vptr, sptr;

  logic [NR-1:0]  is_owner;
  logic [VW-1:0]  own_vc [NR];
  logic [NR-1:0]  velig, selig;
  logic [VW-1:0]  vfree, svc;
  logic           vfree_any, vwin_vld, swin_vld, valloc, sgnt;
  logic [IW-1:0]  vwin, swin;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NR - 1) ? '0 : i + 1'b1;
  endfunction

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    is_owner = '0;
    for (int i = 0; i < NR; i++) own_vc[i] = '0;
    for (int v = 0; v < VCN; v++) begin
      if (owned[v]) begin
        is_owner[owner[v]] = 1'b1;
        own_vc[owner[v]]   = VW'(v);
      end
    end
  end

  // Lowest-index free VC; freed-this-cycle VCs still read as owned.
  always_comb begin
    vfree     = '0;
    vfree_any = 1'b0;
    for (int v = VCN - 1; v >= 0; v--) begin
      if (!owned[v]) begin
        vfree     = VW'(v);
        vfree_any = 1'b1;
      end
    end
  end

  always_comb begin
    velig = vreq & ~is_owner;
    for (int i = 0; i < NR; i++)
      selig[i] = freq[i] && is_owner[i] && (cr[own_vc[i]] != '0);
  end

  always_comb begin
    vwin_vld = 1'b0;
    vwin     = '0;
    swin_vld = 1'b0;
    swin     = '0;
    for (int k = 0; k < NR; k++) begin
      if (!vwin_vld && velig[(int'(vptr) + k) % NR]) begin
        vwin_vld = 1'b1;
        vwin     = IW'((int'(vptr) + k) % NR);
      end
      if (!swin_vld && selig[(int'(sptr) + k) % NR]) begin
        swin_vld = 1'b1;
        swin     = IW'((int'(sptr) + k) % NR);
      end
    end
  end

  assign valloc  = !rst && vwin_vld && vfree_any;
  assign sgnt    = !rst && swin_vld;
  assign svc     = own_vc[swin];

  assign vgnt    = valloc ? (NR'(1) << vwin)   : '0;
  assign vgnt_vc = valloc ? (VCN'(1) << vfree) : '0;
  assign fgnt    = sgnt   ? (NR'(1) << swin)   : '0;
  assign fvc     = sgnt   ? (VCN'(1) << svc)   : '0;
  assign fvld    = sgnt;
  assign vc_busy = owned;

  always_comb begin
    for (int v = 0; v < VCN; v++) cr_cnt[v*CW +: CW] = cr[v];
  end

  // NOTE: state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      owned  <= '0;
      vptr   <= '0;
      sptr   <= '0;
      cr_err <= 1'b0;
      // NOTE: owner[] is qualified by owned[], so its reset only keeps simulation X-free.
      for (int v = 0; v < VCN; v++) begin
        owner[v] <= '0;
        cr[v]    <= CW'(FCPD);
      end
    end else begin
      if (valloc) begin
        owned[vfree] <= 1'b1;
        owner[vfree] <= vwin;
        vptr         <= nxt(vwin);
      end
      if (sgnt) begin
        sptr <= nxt(swin);
        if (ftail[swin]) owned[svc] <= 1'b0;
      end
      for (int v = 0; v < VCN; v++) begin
        if (credit[v] && !(sgnt && svc == VW'(v))) begin
          if (cr[v] == CW'(FCPD)) cr_err <= 1'b1;
          else                    cr[v]  <= cr[v] + 1'b1;
        end else if (!credit[v] && sgnt && svc == VW'(v)) begin
          cr[v] <= cr[v] - 1'b1;
        end
      end
    end
  end

endmodule
